// File: rtl/morse_adaptive_decoder.sv
// Adaptive Morse key decoder: learns a dot/dash threshold from calibration presses,
// then classifies live presses into symbols and emits packed letters and word gaps.
module morse_adaptive_decoder #(
   parameter int CNT_W    = 16,
   parameter int MAX_SYMS = 6,
   parameter int CAL_LOG2 = 2,
   parameter int LEN_W    = 3
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                key_i,
   input  logic                cal_en_i,
   input  logic                dec_en_i,
   output logic                calibrated_o,
   output logic [CNT_W-1:0]    threshold_o,
   output logic                letter_valid_o,
   output logic [MAX_SYMS-1:0] letter_code_o,
   output logic [LEN_W-1:0]    letter_len_o,
   output logic                letter_err_o,
   output logic                word_gap_o,
   output logic [2:0]          state_o
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CAL_DOT  = 3'd1,
      CAL_DASH = 3'd2,
      CALC     = 3'd3,
      WAIT     = 3'd4,
      PRESS    = 3'd5,
      GAP      = 3'd6
   } state_e;

   localparam int                  ACC_W    = CNT_W + CAL_LOG2;
   localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
   localparam logic [LEN_W-1:0]    SYM_MAX  = LEN_W'(MAX_SYMS);
   localparam logic [CAL_LOG2-1:0] CAL_LAST = '1;

   state_e                state_q, state_d;
   logic                  keyPrev_q;
   logic [CNT_W-1:0]      pressCnt_q, pressCnt_d;
   logic [CNT_W-1:0]      gapCnt_q, gapCnt_d;
   logic [ACC_W-1:0]      accDot_q, accDot_d;
   logic [ACC_W-1:0]      accDash_q, accDash_d;
   logic [CAL_LOG2-1:0]   calCnt_q, calCnt_d;
   logic                  calibrated_q, calibrated_d;
   logic [CNT_W-1:0]      threshold_q, threshold_d;
   logic [MAX_SYMS-1:0]   letterBits_q, letterBits_d;
   logic [LEN_W-1:0]      symCnt_q, symCnt_d;
   logic                  errFlag_q, errFlag_d;
   logic                  letterValid_q, letterValid_d;
   logic [MAX_SYMS-1:0]   letterCode_q, letterCode_d;
   logic [LEN_W-1:0]      letterLen_q, letterLen_d;
   logic                  letterErr_q, letterErr_d;
   logic                  wordGap_q, wordGap_d;

   logic                  releaseEv, riseEv, isDash, gapIsWord;
   logic                  enterCal, emitLetter;
   logic [CNT_W-1:0]      dotAvg, dashAvg;
   logic [CNT_W:0]        avgSum;
   logic [CNT_W+1:0]      thrTriple;

   assign releaseEv = keyPrev_q & ~key_i;
   assign riseEv    = key_i & ~keyPrev_q;
   assign isDash    = (pressCnt_q >= threshold_q);
   assign dotAvg    = accDot_q[ACC_W-1:CAL_LOG2];
   assign dashAvg   = accDash_q[ACC_W-1:CAL_LOG2];
   assign avgSum    = {1'b0, dotAvg} + {1'b0, dashAvg};
   assign thrTriple = {2'b00, threshold_q} + {1'b0, threshold_q, 1'b0};
   assign gapIsWord = ({2'b00, gapCnt_q} == thrTriple);

   // Press length runs independently of the FSM; it holds the finished duration on the release sample.
   always_comb begin
      pressCnt_d = pressCnt_q;
      if (key_i) begin
         if (!keyPrev_q) begin
            pressCnt_d = CNT_W'(1);
         end else if (pressCnt_q != CNT_MAX) begin
            pressCnt_d = pressCnt_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      gapCnt_d      = gapCnt_q;
      accDot_d      = accDot_q;
      accDash_d     = accDash_q;
      calCnt_d      = calCnt_q;
      calibrated_d  = calibrated_q;
      threshold_d   = threshold_q;
      letterBits_d  = letterBits_q;
      symCnt_d      = symCnt_q;
      errFlag_d     = errFlag_q;
      letterValid_d = 1'b0;
      letterCode_d  = letterCode_q;
      letterLen_d   = letterLen_q;
      letterErr_d   = letterErr_q;
      wordGap_d     = 1'b0;
      enterCal      = 1'b0;
      emitLetter    = 1'b0;

      case (state_q)
         IDLE: begin
            if (cal_en_i) begin
               enterCal = 1'b1;
            end else if (dec_en_i && calibrated_q) begin
               state_d = WAIT;
            end
         end
         CAL_DOT, CAL_DASH: begin
            if (!cal_en_i) begin
               state_d = IDLE;
            end else if (releaseEv) begin
               if (state_q == CAL_DOT) begin
                  accDot_d = accDot_q + ACC_W'(pressCnt_q);
               end else begin
                  accDash_d = accDash_q + ACC_W'(pressCnt_q);
               end
               calCnt_d = calCnt_q + 1'b1;
               if (calCnt_q == CAL_LAST) begin
                  state_d = (state_q == CAL_DOT) ? CAL_DASH : CALC;
               end
            end
         end
         CALC: begin
            threshold_d  = avgSum[CNT_W:1];
            calibrated_d = 1'b1;
            state_d      = IDLE;
         end
         WAIT: begin
            if (cal_en_i) begin
               enterCal = 1'b1;
            end else if (!dec_en_i) begin
               state_d = IDLE;
            end else if (riseEv) begin
               state_d = PRESS;
            end
         end
         PRESS: begin
            if (cal_en_i) begin
               enterCal = 1'b1;
            end else if (!dec_en_i) begin
               emitLetter = (symCnt_q != '0);
               state_d    = IDLE;
            end else if (!key_i) begin
               if (symCnt_q < SYM_MAX) begin
                  for (int i = 0; i < MAX_SYMS; i++) begin
                     if (symCnt_q == LEN_W'(i)) letterBits_d[i] = isDash;
                  end
                  symCnt_d = symCnt_q + 1'b1;
               end else begin
                  errFlag_d = 1'b1;
               end
               gapCnt_d = '0;
               state_d  = GAP;
            end
         end
         GAP: begin
            if (cal_en_i) begin
               enterCal = 1'b1;
            end else if (!dec_en_i) begin
               emitLetter = (symCnt_q != '0);
               state_d    = IDLE;
            end else begin
               if (gapCnt_q == threshold_q) emitLetter = 1'b1;
               if (gapIsWord) begin
                  wordGap_d = 1'b1;
                  state_d   = WAIT;
               end else if (key_i) begin
                  state_d = PRESS;
               end
               if (gapCnt_q != CNT_MAX) gapCnt_d = gapCnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Recalibration always starts from a clean slate, dropping any half-built letter silently.
      if (enterCal) begin
         state_d      = CAL_DOT;
         calibrated_d = 1'b0;
         accDot_d     = '0;
         accDash_d    = '0;
         calCnt_d     = '0;
         letterBits_d = '0;
         symCnt_d     = '0;
         errFlag_d    = 1'b0;
      end

      if (emitLetter) begin
         letterValid_d = 1'b1;
         letterCode_d  = letterBits_q;
         letterLen_d   = symCnt_q;
         letterErr_d   = errFlag_q;
         letterBits_d  = '0;
         symCnt_d      = '0;
         errFlag_d     = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         keyPrev_q     <= 1'b0;
         pressCnt_q    <= '0;
         gapCnt_q      <= '0;
         accDot_q      <= '0;
         accDash_q     <= '0;
         calCnt_q      <= '0;
         calibrated_q  <= 1'b0;
         threshold_q   <= '0;
         letterBits_q  <= '0;
         symCnt_q      <= '0;
         errFlag_q     <= 1'b0;
         letterValid_q <= 1'b0;
         letterCode_q  <= '0;
         letterLen_q   <= '0;
         letterErr_q   <= 1'b0;
         wordGap_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         keyPrev_q     <= key_i;
         pressCnt_q    <= pressCnt_d;
         gapCnt_q      <= gapCnt_d;
         accDot_q      <= accDot_d;
         accDash_q     <= accDash_d;
         calCnt_q      <= calCnt_d;
         calibrated_q  <= calibrated_d;
         threshold_q   <= threshold_d;
         letterBits_q  <= letterBits_d;
         symCnt_q      <= symCnt_d;
         errFlag_q     <= errFlag_d;
         letterValid_q <= letterValid_d;
         letterCode_q  <= letterCode_d;
         letterLen_q   <= letterLen_d;
         letterErr_q   <= letterErr_d;
         wordGap_q     <= wordGap_d;
      end
   end

   assign calibrated_o   = calibrated_q;
   assign threshold_o    = threshold_q;
   assign letter_valid_o = letterValid_q;
   assign letter_code_o  = letterCode_q;
   assign letter_len_o   = letterLen_q;
   assign letter_err_o   = letterErr_q;
   assign word_gap_o     = wordGap_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_morse_adaptive_decoder.sv
// Bench for morse_adaptive_decoder: directed scenarios plus random key traffic,
// compared every cycle against a behavioural decoder model.
module tb_morse_adaptive_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        key = 1'b0;
   logic        calEn = 1'b0;
   logic        decEn = 1'b0;

   logic        calibrated;
   logic [15:0] threshold;
   logic        letterValid;
   logic [5:0]  letterCode;
   logic [2:0]  letterLen;
   logic        letterErr;
   logic        wordGap;
   logic [2:0]  state;

   logic        sCalibrated;
   logic [3:0]  sThreshold;
   logic        sLetterValid;
   logic [5:0]  sLetterCode;
   logic [2:0]  sLetterLen;
   logic        sLetterErr;
   logic        sWordGap;
   logic [2:0]  sState;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   morse_adaptive_decoder #(.CNT_W(16), .MAX_SYMS(6), .CAL_LOG2(2), .LEN_W(3)) dut (
      .clk_i(clk), .rst_ni(rst_n), .key_i(key), .cal_en_i(calEn), .dec_en_i(decEn),
      .calibrated_o(calibrated), .threshold_o(threshold), .letter_valid_o(letterValid),
      .letter_code_o(letterCode), .letter_len_o(letterLen), .letter_err_o(letterErr),
      .word_gap_o(wordGap), .state_o(state)
   );

   morse_adaptive_decoder #(.CNT_W(4), .MAX_SYMS(6), .CAL_LOG2(2), .LEN_W(3)) u_sat (
      .clk_i(clk), .rst_ni(rst_n), .key_i(key), .cal_en_i(calEn), .dec_en_i(decEn),
      .calibrated_o(sCalibrated), .threshold_o(sThreshold), .letter_valid_o(sLetterValid),
      .letter_code_o(sLetterCode), .letter_len_o(sLetterLen), .letter_err_o(sLetterErr),
      .word_gap_o(sWordGap), .state_o(sState)
   );

   // Behavioural model: modes follow the documented state numbering.
   localparam int SAT = 65535;
   int mMode = 0, mPress = 0, mGap = 0, mDotSum = 0, mDashSum = 0, mCount = 0, mThr = 0;
   bit mKeyWas = 0, mCal = 0, mOverflow = 0;
   bit mSyms[$];
   bit eValid = 0, eWord = 0, eErr = 0;
   int eCode = 0, eLen = 0;

   task automatic modelReset();
      mMode = 0; mPress = 0; mGap = 0; mDotSum = 0; mDashSum = 0; mCount = 0; mThr = 0;
      mKeyWas = 0; mCal = 0; mOverflow = 0; mSyms.delete();
      eValid = 0; eWord = 0; eErr = 0; eCode = 0; eLen = 0;
   endtask

   task automatic modelEmit();
      eValid = 1;
      eCode = 0;
      foreach (mSyms[i]) eCode = eCode | (int'(mSyms[i]) << i);
      eLen = mSyms.size();
      eErr = mOverflow;
      mSyms.delete();
      mOverflow = 0;
   endtask

   task automatic modelStartCal();
      mMode = 1; mCal = 0; mDotSum = 0; mDashSum = 0; mCount = 0;
      mSyms.delete(); mOverflow = 0;
   endtask

   task automatic modelStep();
      bit released, rose;
      int d;
      released = mKeyWas && !key;
      rose = key && !mKeyWas;
      d = mPress;
      eValid = 0;
      eWord = 0;
      case (mMode)
         0: begin
            if (calEn) modelStartCal();
            else if (decEn && mCal) mMode = 4;
         end
         1, 2: begin
            if (!calEn) mMode = 0;
            else if (released) begin
               if (mMode == 1) mDotSum += d; else mDashSum += d;
               mCount++;
               if (mCount == 4) begin
                  mCount = 0;
                  mMode = (mMode == 1) ? 2 : 3;
               end
            end
         end
         3: begin
            mThr = ((mDotSum / 4) + (mDashSum / 4)) / 2;
            mCal = 1;
            mMode = 0;
         end
         default: begin
            if (calEn) modelStartCal();
            else if (!decEn) begin
               if (mSyms.size() > 0) modelEmit();
               mMode = 0;
            end else if (mMode == 4) begin
               if (rose) mMode = 5;
            end else if (mMode == 5) begin
               if (!key) begin
                  if (mSyms.size() < 6) mSyms.push_back(d >= mThr);
                  else mOverflow = 1;
                  mGap = 0;
                  mMode = 6;
               end
            end else begin
               if (mGap == mThr) modelEmit();
               if (mGap == 3 * mThr) begin
                  eWord = 1;
                  mMode = 4;
               end else if (key) mMode = 5;
               if (mGap < SAT) mGap++;
            end
         end
      endcase
      if (key) mPress = mKeyWas ? ((mPress < SAT) ? mPress + 1 : SAT) : 1;
      mKeyWas = key;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) modelReset();
         else modelStep();
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      checks++;
      if (state !== 3'(mMode) || calibrated !== mCal || threshold !== 16'(mThr) ||
          letterValid !== eValid || wordGap !== eWord || letterCode !== 6'(eCode) ||
          letterLen !== 3'(eLen) || letterErr !== eErr) begin
         errors++;
         $display("[TB] FAIL cycle t=%0t: got state=%0d cal=%0d thr=%0d valid=%0d word=%0d code=%b len=%0d err=%0d; expected state=%0d cal=%0d thr=%0d valid=%0d word=%0d code=%b len=%0d err=%0d",
                  $time, state, calibrated, threshold, letterValid, wordGap, letterCode, letterLen, letterErr,
                  mMode, mCal, mThr, eValid, eWord, 6'(eCode), eLen, eErr);
      end
   end

   // Strobe capture used by the literal expectations.
   int validCount = 0, wordCount = 0, sValidCount = 0, sWordCount = 0;
   int lastCode = 0, lastLen = 0, lastErr = 0, sLastCode = 0, sLastLen = 0;
   always @(negedge clk) begin
      if (letterValid) begin
         validCount++;
         lastCode = int'(letterCode);
         lastLen = int'(letterLen);
         lastErr = int'(letterErr);
      end
      if (wordGap) wordCount++;
      if (sLetterValid) begin
         sValidCount++;
         sLastCode = int'(sLetterCode);
         sLastLen = int'(sLetterLen);
      end
      if (sWordGap) sWordCount++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int ones, input int zeros);
      if (ones > 0) begin
         key = 1'b1;
         repeat (ones) tick();
      end
      key = 1'b0;
      repeat (zeros) tick();
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic randomCalibration();
      calEn = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) begin
         applyStimulus((k < 4) ? $urandom_range(1, 8) : $urandom_range(12, 40),
                       (k == 7) ? 2 : $urandom_range(1, 4));
      end
      calEn = 1'b0;
   endtask

   initial begin
      int v0, w0, sv0;
      #1 rst_n = 1'b0;
      repeat (3) tick();
      checkOutput("reset_state", int'(state), 0);
      checkOutput("reset_threshold", int'(threshold), 0);
      rst_n = 1'b1;
      tick();

      $display("[TB] reset in the middle of calibration");
      calEn = 1'b1;
      tick();
      applyStimulus(2, 2);
      applyStimulus(3, 2);
      rst_n = 1'b0;
      repeat (3) tick();
      checkOutput("midcal_reset_state", int'(state), 0);
      checkOutput("midcal_reset_calibrated", int'(calibrated), 0);
      checkOutput("midcal_reset_outputs", int'({letterValid, letterCode, letterLen, letterErr, wordGap}), 0);
      calEn = 1'b0;
      rst_n = 1'b1;
      tick();

      $display("[TB] calibration 2/20");
      calEn = 1'b1;
      tick();
      repeat (4) applyStimulus(2, 2);
      repeat (4) applyStimulus(20, 2);
      calEn = 1'b0;
      checkOutput("cal_threshold", int'(threshold), 11);
      checkOutput("cal_calibrated", int'(calibrated), 1);

      $display("[TB] letter dot-dash and word gap");
      decEn = 1'b1;
      tick();
      v0 = validCount; w0 = wordCount;
      applyStimulus(2, 2);
      applyStimulus(20, 40);
      checkOutput("dotdash_strobes", validCount - v0, 1);
      checkOutput("dotdash_code", lastCode, 2);
      checkOutput("dotdash_len", lastLen, 2);
      checkOutput("dotdash_err", lastErr, 0);
      checkOutput("dotdash_wordgap", wordCount - w0, 1);

      $display("[TB] overflow letter");
      repeat (7) applyStimulus(2, 2);
      applyStimulus(0, 40);
      checkOutput("overflow_len", lastLen, 6);
      checkOutput("overflow_code", lastCode, 0);
      checkOutput("overflow_err", lastErr, 1);
      applyStimulus(20, 40);
      checkOutput("after_overflow_err", lastErr, 0);
      checkOutput("after_overflow_code", lastCode, 1);

      $display("[TB] boundary 11 vs 10");
      applyStimulus(11, 2);
      applyStimulus(10, 40);
      checkOutput("boundary_code", lastCode, 1);
      checkOutput("boundary_len", lastLen, 2);

      $display("[TB] calibration request mid-letter");
      v0 = validCount;
      applyStimulus(2, 2);
      calEn = 1'b1;
      tick();
      checkOutput("midletter_state", int'(state), 1);
      checkOutput("midletter_calibrated", int'(calibrated), 0);
      calEn = 1'b0;
      tick();
      tick();
      checkOutput("midletter_no_strobe", validCount - v0, 0);
      checkOutput("abort_threshold", int'(threshold), 11);

      $display("[TB] saturation with narrow counters");
      calEn = 1'b1;
      tick();
      repeat (4) applyStimulus(2, 2);
      repeat (4) applyStimulus(40, 2);
      calEn = 1'b0;
      checkOutput("sat_threshold", int'(sThreshold), 8);
      checkOutput("sat_calibrated", int'(sCalibrated), 1);
      checkOutput("wide_threshold", int'(threshold), 21);
      tick();
      sv0 = sValidCount;
      applyStimulus(40, 80);
      checkOutput("sat_strobes", sValidCount - sv0, 1);
      checkOutput("sat_code", sLastCode, 1);
      checkOutput("sat_len", sLastLen, 1);

      $display("[TB] decode disable mid-letter");
      v0 = validCount;
      applyStimulus(2, 2);
      decEn = 1'b0;
      tick();
      tick();
      checkOutput("decoff_strobes", validCount - v0, 1);
      checkOutput("decoff_len", lastLen, 1);
      checkOutput("decoff_state", int'(state), 0);

      $display("[TB] random traffic");
      decEn = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (i % 60 == 0) randomCalibration();
         if ($urandom_range(0, 14) == 0) begin
            decEn = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            decEn = 1'b1;
         end
         applyStimulus($urandom_range(1, 45), $urandom_range(1, 90));
      end
      applyStimulus(0, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
